lsq_multiport_ram: RTL and testbench
====================================

# lsq_multiport_ram

Parametrised multi-write, multi-read register-array RAM for load/store-queue side tables (store-following-load, load-following-store and similar per-entry tags). It generalises the single-read dispatch-written queue RAMs to N write and M read ports. It adds per-port and per-partition gating and a built-in sequential reset sweep that drives a ready flag. It sits inside the LSQ, written by dispatch lanes and read by execute/disambiguation logic.

## Interface
- DEPTH, 32, total entries; multiple of NUM_PARTS
- INDEX, 5, log2(DEPTH)
- WIDTH, 8, entry width in bits
- NUM_WR, 4, write ports (one per dispatch lane)
- NUM_RD, 2, read ports
- NUM_PARTS, 4, power-of-two partitions, each DEPTH/NUM_PARTS rows
- SEQ_START, 0, 0: rows reset to zero; 1: row r resets to r[WIDTH-1:0]

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wrEn_i  in  NUM_WR  per-port write enable
- addrWr_i  in  NUM_WR×INDEX  write addresses
- dataWr_i  in  NUM_WR×WIDTH  write data
- wrPortGated_i  in  NUM_WR  1 = port powered down; its writes are ignored
- partGated_i  in  NUM_PARTS  1 = partition powered down
- addrRd_i  in  NUM_RD×INDEX  read addresses
- dataRd_o  out  NUM_RD×WIDTH  read data, combinational
- ready_o  out  1  registered; 1 = sweep complete, RAM usable
- wrDropped_o  out  1  registered pulse; an enabled, ungated-port write was discarded

## Operation
- Partition of an address: addr[INDEX-1 : INDEX-log2(NUM_PARTS)]. Row-in-partition: remaining low bits.
- FSM states: RESET, SWEEP, READY.
  - Any cycle with reset=1 → RESET, sweep counter = 0.
  - RESET → SWEEP on the first cycle with reset=0.
  - In SWEEP, each cycle writes the reset value to row cnt of every partition, gated partitions included. Counter increments each cycle.
  - SWEEP → READY after row PART_DEPTH-1 is written.
  - READY persists until reset.
- Write in READY: enabled, port ungated, target partition ungated → entry updated at the edge.
  - Same address on several ports in one cycle: the highest-index port wins.
  - Writes to gated partitions are discarded and pulse wrDropped_o. Writes from gated ports are ignored silently.
- Writes in RESET or SWEEP are discarded and pulse wrDropped_o.
- Read: dataRd_o[k] = ram[addrRd_i[k]] asynchronously.
  - Forced to 0 when the target partition is gated or ready_o=0.
  - Reads return pre-edge contents; no same-cycle write visibility unless bypass is enabled (see Configuration).
- Gating a partition retains its contents. Ungating makes them readable again unchanged.

## Timing
- Reset values: ready_o=0, wrDropped_o=0, FSM=RESET.
- ready_o rises exactly PART_DEPTH+1 edges after the first edge with reset=0.
- Write latency: 1 cycle; the read in the next cycle sees new data.
- Reset asserted mid-sweep or mid-operation: next edge ready_o=0, counter=0, sweep restarts on deassertion.

## Configuration
- LSQ_RAM_BYPASS_EN defined: each read port returns same-cycle write data combinationally when an accepted write in READY targets its address. The highest-index matching port wins.
- LSQ_RAM_BYPASS_EN undefined: no bypass; reads see pre-edge contents only.

## Structure
- Package lsq_ram_pkg holds:
  - typedef enum for RESET/SWEEP/READY
  - partition-index function
  - reset-value function (SEQ_START handling)
- Sub-module lsq_ram_reset_seq holds the FSM, sweep counter and ready_o register. The top holds the array, write arbitration, read muxes and bypass.

## Test plan
- Reset 3 cycles, DEPTH=32, NUM_PARTS=4 → ready_o=0 for 8 cycles after deassert, 1 on the 9th; all reads 0. With SEQ_START=1, read addr 13 → 13.
- In READY: port0 and port3 both write addr 5, data 0x11 and 0x33 → next cycle read addr 5 = 0x33.
- partGated_i=4'b0010, write addr 9 data 0xAA → wrDropped_o pulses; read addr 9 = 0. Ungate → read addr 9 = value held before gating.
- wrPortGated_i[1]=1, port1 writes addr 2 data 0x7F → addr 2 unchanged; wrDropped_o stays 0.
- Write addr 4 data 0x5A while reading addr 4 → 0x5A in the same cycle with LSQ_RAM_BYPASS_EN, old value without it.
- Reset asserted at sweep row 3 → ready_o stays 0; full 8-cycle sweep reruns after deassertion.

Source files
------------

// File: rtl/lsq_ram_pkg.sv
// Shared types and helpers for the LSQ multi-port side-table RAM.
package lsq_ram_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_SWEEP = 2'd1,
      ST_READY = 2'd2
   } ram_state_e;

   // Partition number is the top part_bits of an index-bit address.
   function automatic int unsigned part_of(input logic [31:0] addr,
                                           input int unsigned index,
                                           input int unsigned part_bits);
      return 32'(addr >> (index - part_bits));
   endfunction

   // Value a row takes during the sweep; callers slice to the entry width.
   function automatic logic [31:0] reset_value(input logic [31:0] row,
                                               input int unsigned seq_start);
      return (seq_start != 32'd0) ? row : 32'd0;
   endfunction

endpackage

// File: rtl/lsq_ram_reset_seq.sv
// Reset sequencer: walks one row per partition per cycle, then raises ready.
module lsq_ram_reset_seq
   import lsq_ram_pkg::*;
#(
   parameter int ROW_BITS   = 3,
   parameter int PART_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   output logic                sweep_en,
   output logic [ROW_BITS-1:0] sweep_row,
   output logic                ready_o
);

   localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(PART_DEPTH - 1);

   ram_state_e          state;
   ram_state_e          state_next;
   logic [ROW_BITS-1:0] cnt;
   logic [ROW_BITS-1:0] cnt_next;

   // State, counter and ready register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RESET;
         cnt     <= '0;
         ready_o <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         ready_o <= (state_next == ST_READY);
      end
   end

   // Next-state and sweep counter logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_RESET: begin
            state_next = ST_SWEEP;
            cnt_next   = '0;
         end
         ST_SWEEP: begin
            cnt_next = cnt + ROW_ONE;
            if (cnt == ROW_LAST) begin
               state_next = ST_READY;
            end else begin
               state_next = ST_SWEEP;
            end
         end
         ST_READY: begin
            state_next = ST_READY;
         end
         default: begin
            state_next = ST_RESET;
            cnt_next   = '0;
         end
      endcase
   end

   assign sweep_en  = (state == ST_SWEEP);
   assign sweep_row = cnt;

endmodule

// File: rtl/lsq_multiport_ram.sv
// Multi-write/multi-read LSQ side-table RAM with port/partition gating and a reset sweep.
// Optional same-cycle write-to-read bypass is built when LSQ_RAM_BYPASS_EN is defined.
module lsq_multiport_ram
   import lsq_ram_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int INDEX     = 5,
   parameter int WIDTH     = 8,
   parameter int NUM_WR    = 4,
   parameter int NUM_RD    = 2,
   parameter int NUM_PARTS = 4,
   parameter int SEQ_START = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_WR-1:0]                wrEn_i,
   input  logic [NUM_WR-1:0][INDEX-1:0]     addrWr_i,
   input  logic [NUM_WR-1:0][WIDTH-1:0]     dataWr_i,
   input  logic [NUM_WR-1:0]                wrPortGated_i,
   input  logic [NUM_PARTS-1:0]             partGated_i,
   input  logic [NUM_RD-1:0][INDEX-1:0]     addrRd_i,
   output logic [NUM_RD-1:0][WIDTH-1:0]     dataRd_o,
   output logic                             ready_o,
   output logic                             wrDropped_o
);

   localparam int PART_BITS  = $clog2(NUM_PARTS);
   localparam int ROW_BITS   = INDEX - PART_BITS;
   localparam int PART_DEPTH = DEPTH / NUM_PARTS;

   logic [WIDTH-1:0]    ram [DEPTH];
   logic                sweep_en;
   logic [ROW_BITS-1:0] sweep_row;
   logic [NUM_WR-1:0]   accept;
   logic [NUM_WR-1:0]   dropped;

   lsq_ram_reset_seq #(
      .ROW_BITS   (ROW_BITS),
      .PART_DEPTH (PART_DEPTH)
   ) u_reset_seq (
      .clk       (clk),
      .reset     (reset),
      .sweep_en  (sweep_en),
      .sweep_row (sweep_row),
      .ready_o   (ready_o)
   );

   // Per-port acceptance; an enabled ungated-port write that is not accepted is a drop.
   always_comb begin
      accept  = '0;
      dropped = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wrEn_i[p] && !wrPortGated_i[p]) begin
            if (ready_o && !partGated_i[PART_BITS'(part_of(32'(addrWr_i[p]), INDEX, PART_BITS))]) begin
               accept[p] = 1'b1;
            end else begin
               dropped[p] = 1'b1;
            end
         end else begin
            accept[p]  = 1'b0;
            dropped[p] = 1'b0;
         end
      end
   end

   // Array update: sweep rows in every partition, else ordered port writes (later port wins).
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (sweep_en) begin
            for (int q = 0; q < NUM_PARTS; q++) begin
               logic [INDEX-1:0] row_addr;
               logic [31:0]      rv;
               row_addr      = {PART_BITS'(q), sweep_row};
               rv            = reset_value(32'(row_addr), SEQ_START);
               ram[row_addr] <= rv[WIDTH-1:0];
            end
         end else begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (accept[p]) begin
                  ram[addrWr_i[p]] <= dataWr_i[p];
               end
            end
         end
      end
   end

   // Drop indication, one cycle after the discarded write.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrDropped_o <= 1'b0;
      end else begin
         wrDropped_o <= |dropped;
      end
   end

   // Read muxes: zero while not ready or when the partition is gated.
   always_comb begin
      dataRd_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (ready_o && !partGated_i[PART_BITS'(part_of(32'(addrRd_i[k]), INDEX, PART_BITS))]) begin
            dataRd_o[k] = ram[addrRd_i[k]];
`ifdef LSQ_RAM_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++) begin
               if (accept[p] && (addrWr_i[p] == addrRd_i[k])) begin
                  dataRd_o[k] = dataWr_i[p];
               end
            end
`endif
         end else begin
            dataRd_o[k] = '0;
         end
      end
   end

endmodule

// File: tb/tb_lsq_multiport_ram.sv
// Directed bench for lsq_multiport_ram (SEQ_START=1, so swept rows hold their own address).
module tb_lsq_multiport_ram;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       wr_en;
   logic [3:0][4:0]  addr_wr;
   logic [3:0][7:0]  data_wr;
   logic [3:0]       wr_port_gated;
   logic [3:0]       part_gated;
   logic [1:0][4:0]  addr_rd;
   logic [1:0][7:0]  data_rd;
   logic             ready;
   logic             wr_dropped;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsq_multiport_ram #(
      .DEPTH(32), .INDEX(5), .WIDTH(8), .NUM_WR(4), .NUM_RD(2),
      .NUM_PARTS(4), .SEQ_START(1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wrEn_i        (wr_en),
      .addrWr_i      (addr_wr),
      .dataWr_i      (data_wr),
      .wrPortGated_i (wr_port_gated),
      .partGated_i   (part_gated),
      .addrRd_i      (addr_rd),
      .dataRd_o      (data_rd),
      .ready_o       (ready),
      .wrDropped_o   (wr_dropped)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; wr_en = '0; addr_wr = '0; data_wr = '0;
      wr_port_gated = '0; part_gated = '0; addr_rd = '0;
      step(); step(); step();
      addr_rd[0] = 5'd13; addr_rd[1] = 5'd0;
      #1;
      chk("rst_ready", {7'd0, ready}, 8'd0);
      chk("rst_drop", {7'd0, wr_dropped}, 8'd0);
      chk("rst_rd13", data_rd[0], 8'd0);
      chk("rst_rd0", data_rd[1], 8'd0);

      // Deassert reset; a write during the RESET state is dropped
      reset = 1'b0;
      wr_en = 4'b0001; addr_wr[0] = 5'd3; data_wr[0] = 8'h99;
      step();
      wr_en = '0;
      chk("pre_drop", {7'd0, wr_dropped}, 8'd1);
      chk("sweep_ready_1", {7'd0, ready}, 8'd0);
      for (int i = 2; i <= 8; i++) begin
         step();
         chk("sweep_ready", {7'd0, ready}, 8'd0);
         chk("sweep_rd_zero", data_rd[0], 8'd0);
      end
      chk("sweep_drop_clear", {7'd0, wr_dropped}, 8'd0);
      step();
      chk("ready_edge9", {7'd0, ready}, 8'd1);
      chk("seq_rd13", data_rd[0], 8'd13);
      addr_rd[1] = 5'd3;
      #1;
      chk("seq_rd3", data_rd[1], 8'd3);
      addr_rd[1] = 5'd31;
      #1;
      chk("seq_rd31", data_rd[1], 8'd31);

      // Two ports hit addr 5: port 3 wins
      wr_en = 4'b1001;
      addr_wr[0] = 5'd5; data_wr[0] = 8'h11;
      addr_wr[3] = 5'd5; data_wr[3] = 8'h33;
      step();
      wr_en = '0;
      addr_rd[0] = 5'd5;
      #1;
      chk("prio_rd5", data_rd[0], 8'h33);
      chk("prio_nodrop", {7'd0, wr_dropped}, 8'd0);

      // Partition gating: write 0x5C to addr 9, gate partition 1, attempt 0xAA
      wr_en = 4'b0001; addr_wr[0] = 5'd9; data_wr[0] = 8'h5C;
      step();
      wr_en = '0;
      addr_rd[0] = 5'd9; addr_rd[1] = 5'd1;
      #1;
      chk("gate_pre_rd9", data_rd[0], 8'h5C);
      part_gated = 4'b0010;
      #1;
      chk("gate_rd9_zero", data_rd[0], 8'd0);
      chk("gate_rd1_open", data_rd[1], 8'd1);
      wr_en = 4'b0001; addr_wr[0] = 5'd9; data_wr[0] = 8'hAA;
      step();
      wr_en = '0;
      chk("gate_drop", {7'd0, wr_dropped}, 8'd1);
      chk("gate_rd9_still0", data_rd[0], 8'd0);
      step();
      chk("gate_drop_clear", {7'd0, wr_dropped}, 8'd0);
      part_gated = '0;
      #1;
      chk("ungate_rd9", data_rd[0], 8'h5C);

      // Gated write port: silently ignored
      wr_port_gated = 4'b0010;
      wr_en = 4'b0010; addr_wr[1] = 5'd2; data_wr[1] = 8'h7F;
      step();
      wr_en = '0; wr_port_gated = '0;
      addr_rd[0] = 5'd2;
      #1;
      chk("pgate_rd2", data_rd[0], 8'd2);
      chk("pgate_nodrop", {7'd0, wr_dropped}, 8'd0);

      // Same-cycle write/read of addr 4
      addr_rd[0] = 5'd4;
      wr_en = 4'b0100; addr_wr[2] = 5'd4; data_wr[2] = 8'h5A;
      #1;
`ifdef LSQ_RAM_BYPASS_EN
      chk("bypass_rd4", data_rd[0], 8'h5A);
`else
      chk("nobypass_rd4", data_rd[0], 8'd4);
`endif
      step();
      wr_en = '0;
      chk("after_wr_rd4", data_rd[0], 8'h5A);

      // Reset mid-operation, then again mid-sweep at row 3
      reset = 1'b1;
      step();
      chk("midop_ready", {7'd0, ready}, 8'd0);
      reset = 1'b0;
      step(); step(); step(); step();
      chk("midsweep_ready", {7'd0, ready}, 8'd0);
      reset = 1'b1;
      step();
      chk("midsweep_rst_ready", {7'd0, ready}, 8'd0);
      reset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("resweep_ready", {7'd0, ready}, 8'd0);
      end
      step();
      chk("resweep_ready9", {7'd0, ready}, 8'd1);
      chk("resweep_rd4", data_rd[0], 8'd4);
      addr_rd[1] = 5'd5;
      #1;
      chk("resweep_rd5", data_rd[1], 8'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
